// File: rtl/cpu_pkg.sv
// Shared opcode/step definitions for the instruction sequencer and control_matrix.
// Step-length and memory-step helpers live here so both blocks decode identically.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_LDW  = 4'h2;
  localparam logic [3:0] OP_STW  = 4'h3;
  localparam logic [3:0] OP_RTR  = 4'h4;
  localparam logic [3:0] OP_BLT  = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd6;

  // HALT, NOP and illegal opcodes all get a single execute step.
  function automatic logic [2:0] last_step(input logic [3:0] opc);
    case (opc)
      OP_LDW, OP_STW, OP_ADD, OP_SUB: last_step = 3'd3;
      OP_RTR, OP_BLT:                 last_step = 3'd2;
      default:                        last_step = 3'd1;
    endcase
  endfunction

  function automatic logic is_mem_step(input logic [3:0] opc, input logic [2:0] st);
    is_mem_step = ((opc == OP_LDW) || (opc == OP_STW)) && (st == 3'd2);
  endfunction

endpackage

// File: rtl/instruction_sequencer_step_counter.sv
// 3-bit step register: increments unless held, with jumps to fetch and to the clear step.
// Latency: next step visible one cycle after the control inputs. No backpressure of its own.
// Encoding 7 is unreachable and recovers to the clear step on the next edge.
module step_counter
  import cpu_pkg::*;
#(
  parameter logic [2:0] CLR_STEP = ST_CLR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       jump_clr,
  input  logic       jump_fetch,
  output logic [2:0] state
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 state <= ST_FETCH;
    else if (state == 3'd7)    state <= CLR_STEP;
    else if (jump_fetch)       state <= ST_FETCH;
    else if (jump_clr)         state <= CLR_STEP;
    else if (!hold)            state <= state + 3'd1;
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Latches fetched instruction words and steps through fetch/execute/clear for control_matrix.
// Latency: opcode valid the cycle after instr_valid is taken in step 0.
// Backpressure: holds in step 0 without instr_valid and in memory steps without mem_ready.
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter int         INSTR_W  = 16,
  parameter int         OPC_W    = 4,
  parameter logic [2:0] CLR_STEP = ST_CLR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               mem_ready,
  input  logic               LT_flag,
  output logic [2:0]         state,
  output logic [OPC_W-1:0]   opcode,
  output logic [3:0]         ra,
  output logic [3:0]         rb,
  output logic [7:0]         imm,
  output logic               fetch_req,
  output logic               branch_flag,
  output logic               halted
);

  logic [INSTR_W-1:0] ir;
  logic hold, jump_clr, jump_fetch, ir_load, br_load;

  assign opcode    = ir[INSTR_W-1 -: OPC_W];
  assign ra        = ir[11:8];
  assign rb        = ir[7:4];
  assign imm       = ir[7:0];
  assign fetch_req = (state == ST_FETCH) && !halted;

  step_counter #(.CLR_STEP(CLR_STEP)) u_step (
    .clock      (clock),
    .reset      (reset),
    .hold       (hold),
    .jump_clr   (jump_clr),
    .jump_fetch (jump_fetch),
    .state      (state)
  );

  always_comb begin
    hold       = 1'b0;
    jump_clr   = 1'b0;
    jump_fetch = 1'b0;
    ir_load    = 1'b0;
    br_load    = 1'b0;
    if (halted) begin
      hold = 1'b1;
    end else begin
      case (state)
        ST_FETCH: begin
          if (instr_valid) ir_load = 1'b1;
          else             hold    = 1'b1;
        end
        CLR_STEP: begin
          // HALT parks in the clear step for good.
          if (opcode == OP_HALT) hold       = 1'b1;
          else                   jump_fetch = 1'b1;
        end
        3'd7: begin
          hold = 1'b0;
        end
        default: begin
          if (is_mem_step(opcode, state) && !mem_ready) begin
            hold = 1'b1;
          end else begin
            br_load  = (opcode == OP_BLT) && (state == 3'd2);
            jump_clr = (state >= last_step(opcode));
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir          <= {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};
      branch_flag <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (ir_load) ir <= instr_in;
      if (jump_fetch || ir_load) branch_flag <= 1'b0;
      else if (br_load)          branch_flag <= LT_flag;
      if (state == CLR_STEP && opcode == OP_HALT) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: expected step sequences are queued when an instruction is issued
// and popped against the DUT state on every falling edge.
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr_in = 16'h0;
  logic        instr_valid = 1'b0;
  logic        mem_ready = 1'b1;
  logic        LT_flag = 1'b0;
  logic [2:0]  state;
  logic [3:0]  opcode, ra, rb;
  logic [7:0]  imm;
  logic        fetch_req, branch_flag, halted;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  always #5 clock = ~clock;

  instruction_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .LT_flag     (LT_flag),
    .state       (state),
    .opcode      (opcode),
    .ra          (ra),
    .rb          (rb),
    .imm         (imm),
    .fetch_req   (fetch_req),
    .branch_flag (branch_flag),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_last(input logic [3:0] opc);
    case (opc)
      4'h2, 4'h3, 4'h6, 4'h7: return 3;
      4'h4, 4'h5:             return 2;
      default:                return 1;
    endcase
  endfunction

  // Issue one instruction from step 0 and follow it until the queue drains.
  task automatic run_instr(input logic [15:0] w, input int stalls, input logic lt,
                           input logic idle_mr, input logic exp_br);
    int last, left;
    logic is_mem;
    logic [2:0] e;
    last   = model_last(w[15:12]);
    is_mem = (w[15:12] == 4'h2) || (w[15:12] == 4'h3);
    left   = stalls;
    exp_q.push_back(3'd1);
    for (int s = 2; s <= last; s++) begin
      exp_q.push_back(3'(s));
      if (is_mem && s == 2)
        for (int k = 0; k < stalls; k++) exp_q.push_back(3'd2);
    end
    exp_q.push_back(3'd6);
    if (w[15:12] != 4'h0) exp_q.push_back(3'd0);

    check("fetch_req_idle", {15'h0, fetch_req}, 16'h1);
    instr_in    = w;
    instr_valid = 1'b1;
    LT_flag     = lt;
    mem_ready   = idle_mr;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      check("state", {13'h0, state}, {13'h0, e});
      if (e == 3'd1) begin
        check("opcode", {12'h0, opcode}, {12'h0, w[15:12]});
        check("ra_rb_imm", {ra, rb, imm}, {w[11:8], w[7:4], w[7:0]});
      end
      if (e == 3'd6) begin
        check("branch_s6", {15'h0, branch_flag}, {15'h0, exp_br});
        check("opcode_kept", {12'h0, opcode}, {12'h0, w[15:12]});
      end
      if (e == 3'd0) check("branch_s0", {15'h0, branch_flag}, 16'h0);
      // Junk word with valid held high outside step 0 must be ignored.
      instr_in    = ~w;
      instr_valid = (exp_q.size() > 0);
      if (is_mem && e == 3'd2 && left > 0) begin
        mem_ready = 1'b0;
        left--;
      end else begin
        mem_ready = is_mem ? 1'b1 : idle_mr;
      end
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_state", {13'h0, state}, 16'h0);
    check("rst_opcode", {12'h0, opcode}, 16'hF);
    check("rst_fetch_req", {15'h0, fetch_req}, 16'h1);
    check("rst_flags", {14'h0, branch_flag, halted}, 16'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("fetch_hold", {13'h0, state}, 16'h0);

    run_instr(16'h2123, 0, 1'b0, 1'b1, 1'b0);   // LDW, no stall
    run_instr(16'h2123, 3, 1'b0, 1'b1, 1'b0);   // LDW, 3 stall cycles
    run_instr(16'h3456, 2, 1'b1, 1'b1, 1'b0);   // STW stall, LT ignored
    run_instr(16'h5120, 0, 1'b1, 1'b0, 1'b1);   // BLT taken
    run_instr(16'h5120, 0, 1'b0, 1'b1, 1'b0);   // BLT not taken
    run_instr(16'hA000, 0, 1'b1, 1'b0, 1'b0);   // illegal
    check("illegal_halted", {15'h0, halted}, 16'h0);
    run_instr(16'h1FFE, 0, 1'b1, 1'b0, 1'b0);   // JMP
    run_instr(16'h4321, 0, 1'b1, 1'b0, 1'b0);   // RTR
    run_instr(16'h6789, 0, 1'b1, 1'b0, 1'b0);   // ADD, mem_ready low ignored
    run_instr(16'h7ABC, 0, 1'b0, 1'b0, 1'b0);   // SUB
    run_instr(16'hF000, 0, 1'b1, 1'b1, 1'b0);   // NOP

    // Async reset in the middle of an LDW memory stall.
    instr_in = 16'h2123; instr_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clock);
    instr_valid = 1'b0;
    check("ldw_s1", {13'h0, state}, 16'h1);
    @(negedge clock);
    check("ldw_s2", {13'h0, state}, 16'h2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state", {13'h0, state}, 16'h0);
    check("mid_rst_opcode", {12'h0, opcode}, 16'hF);
    check("mid_rst_fetch_req", {15'h0, fetch_req}, 16'h1);
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b1;

    // HALT: 1, 6, then frozen in 6 with halted set.
    run_instr(16'h0000, 0, 1'b0, 1'b1, 1'b0);
    instr_in = 16'h1000; instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("halt_state", {13'h0, state}, 16'h6);
      check("halt_flags", {14'h0, halted, fetch_req}, 16'h2);
    end
    instr_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("halt_rst_state", {13'h0, state}, 16'h0);
    check("halt_rst_halted", {15'h0, halted}, 16'h0);
    @(negedge clock);
    reset = 1'b0;
    run_instr(16'h6111, 0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
